nios_pin_entrada: RTL and testbench

//   Avalon-MM slave input PIO. Counterpart of the 3-bit output PIO on the same Nios bus.

---
 rtl/nios_pin_entrada.sv | 103 ++++++++++
 tb/tb_nios_pin_entrada.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_pin_entrada.sv
// Avalon-MM input PIO: pin synchroniser, per-bit edge capture (RW1C) and
// a maskable level interrupt that exists only when NIOS_PIN_ENTRADA_IRQ_EN is defined.
module nios_pin_entrada #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] det, clr;
    logic [2:0]       arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr;
    logic             unused_wd;
`ifdef NIOS_PIN_ENTRADA_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;
`endif

    assign data      = sync_q[SYNC_STAGES-1];
    assign wr        = chipselect & ~write_n;
    assign unused_wd = ^writedata;
    assign readdata  = readdata_q;
    assign irq       = irq_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = data;
        arm_d  = (arm_q == ARM_DONE) ? arm_q : arm_q + 3'd1;

        // prev only holds a real sample once the counter saturates
        det = '0;
        if (arm_q == ARM_DONE) begin
            case (EDGE_TYPE)
                0:       det = data & ~prev_q;
                1:       det = ~data & prev_q;
                default: det = data ^ prev_q;
            endcase
        end

        clr = '0;
        if (wr && address == 2'd3) clr = writedata[WIDTH-1:0];
        edge_d = (edge_q & ~clr) | det;

`ifdef NIOS_PIN_ENTRADA_IRQ_EN
        mask_d = mask_q;
        if (wr && address == 2'd2) mask_d = writedata[WIDTH-1:0];
        irq_d = |(edge_q & mask_q);
`else
        irq_d = 1'b0;
`endif

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(data);
`ifdef NIOS_PIN_ENTRADA_IRQ_EN
            2'd2:    readdata_d = 32'(mask_q);
`endif
            2'd3:    readdata_d = 32'(edge_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            edge_q     <= '0;
            arm_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
`ifdef NIOS_PIN_ENTRADA_IRQ_EN
            mask_q     <= '0;
`endif
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
`ifdef NIOS_PIN_ENTRADA_IRQ_EN
            mask_q     <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_nios_pin_entrada.sv
// Bench for nios_pin_entrada: rising (u0) and falling (u1) instances share
// stimulus and are checked against a pin-history reference model.
module tb_nios_pin_entrada;

    localparam int N = 2;
`ifdef NIOS_PIN_ENTRADA_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [2:0]  in_port;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int total = 0;
    int bad = 0;

    logic [2:0]  hist[$];
    int          e;
    logic [2:0]  m_edge[2];
    logic [2:0]  m_mask;
    logic [31:0] m_rd[2];
    logic        m_irq[2];

    always #5 clk = ~clk;

    nios_pin_entrada #(.WIDTH(3), .SYNC_STAGES(N), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs),
        .write_n(wn), .writedata(wd), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    nios_pin_entrada #(.WIDTH(3), .SYNC_STAGES(N), .EDGE_TYPE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs),
        .write_n(wn), .writedata(wd), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    // pin level sampled at edge j (edge 1 is the first after reset release)
    function automatic logic [2:0] pin_at(int j);
        if (j >= 1 && j <= hist.size()) return hist[j-1];
        return 3'b000;
    endfunction

    // synchronised level after edge x is the pin sampled N-1 edges earlier
    function automatic logic [2:0] data_at(int x);
        return pin_at(x - N + 1);
    endfunction

    task automatic model_reset();
        hist.delete();
        e = 0;
        m_mask = '0;
        for (int t = 0; t < 2; t++) begin
            m_edge[t] = '0;
            m_rd[t]   = '0;
            m_irq[t]  = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [2:0] d_old, p_old, det, clr;
        logic wr;
        hist.push_back(in_port);
        e++;
        d_old = data_at(e - 1);
        p_old = data_at(e - 2);
        wr  = cs && !wn;
        clr = (wr && addr == 2'd3) ? wd[2:0] : 3'b000;
        for (int t = 0; t < 2; t++) begin
            det = 3'b000;
            if (e - 1 >= N + 1)
                det = (t == 0) ? (d_old & ~p_old) : (~d_old & p_old);
            case (addr)
                2'd0:    m_rd[t] = {29'd0, d_old};
                2'd2:    m_rd[t] = {29'd0, m_mask};
                2'd3:    m_rd[t] = {29'd0, m_edge[t]};
                default: m_rd[t] = '0;
            endcase
            m_irq[t]  = IRQ_EN && |(m_edge[t] & m_mask);
            m_edge[t] = (m_edge[t] & ~clr) | det;
        end
        if (IRQ_EN && wr && addr == 2'd2) m_mask = wd[2:0];
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wd = d; cs = 1'b1; wn = 1'b0;
        tick();
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = 3'b101; addr = 2'd0;
        cs = 1'b0; wn = 1'b1; wd = '0;
        model_reset();
        tick();
        total++;
        if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
            bad++; $display("FAIL reset_rd got %0h/%0h exp 0", rd0, rd1);
        end
        total++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            bad++; $display("FAIL reset_irq got %b/%b exp 0", irq0, irq1);
        end
        reset_n = 1'b1;
        repeat (5) tick();
        total++;
        if (rd0 !== 32'd5) begin
            bad++; $display("FAIL reset_data got %0h exp 5", rd0);
        end
        addr = 2'd3;
        tick();
        total++;
        if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
            bad++; $display("FAIL reset_edge got %0h/%0h exp 0", rd0, rd1);
        end
        total++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            bad++; $display("FAIL reset_irq_arm got %b/%b exp 0", irq0, irq1);
        end
    endtask

    task automatic test_rise_irq();
        in_port = 3'b000;
        repeat (4) tick();
        bus_write(2'd3, 32'h7);
        bus_write(2'd2, 32'h2);
        addr = 2'd3;
        repeat (2) tick();
        in_port = 3'b010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (rd0 !== m_rd[0] || rd1 !== m_rd[1]) begin
                bad++;
                $display("FAIL rise_rd c%0d got %0h/%0h exp %0h/%0h",
                         i, rd0, rd1, m_rd[0], m_rd[1]);
            end
            total++;
            if (irq0 !== m_irq[0] || irq1 !== m_irq[1]) begin
                bad++;
                $display("FAIL rise_irq c%0d got %b/%b exp %b/%b",
                         i, irq0, irq1, m_irq[0], m_irq[1]);
            end
            if (i == 3) begin
                total++;
                if (irq0 !== 1'b0) begin
                    bad++; $display("FAIL rise_irq_early got %b exp 0", irq0);
                end
            end
            if (i == 4) begin
                total++;
                if (rd0 !== 32'd2 || irq0 !== IRQ_EN) begin
                    bad++;
                    $display("FAIL rise_k3 got %0h/%b exp 2/%b", rd0, irq0, IRQ_EN);
                end
            end
        end
    endtask

    task automatic test_clear_collision();
        in_port = 3'b000;
        repeat (4) tick();
        in_port = 3'b010;
        tick();
        tick();
        bus_write(2'd3, 32'h2);
        addr = 2'd3;
        tick();
        total++;
        if (rd0 !== 32'd2 || irq0 !== IRQ_EN) begin
            bad++;
            $display("FAIL collide_u0 got %0h/%b exp 2/%b", rd0, irq0, IRQ_EN);
        end
        total++;
        if (rd1 !== m_rd[1] || irq1 !== m_irq[1]) begin
            bad++;
            $display("FAIL collide_u1 got %0h/%b exp %0h/%b", rd1, irq1, m_rd[1], m_irq[1]);
        end
        tick();
        total++;
        if (irq0 !== IRQ_EN) begin
            bad++; $display("FAIL collide_irq got %b exp %b", irq0, IRQ_EN);
        end
    endtask

    task automatic test_clear_all();
        bus_write(2'd3, 32'h7);
        addr = 2'd3;
        tick();
        total++;
        if (rd0 !== 32'd0 || rd1 !== 32'd0 || irq0 !== 1'b0) begin
            bad++; $display("FAIL clear_all got %0h/%0h/%b exp 0/0/0", rd0, rd1, irq0);
        end
        addr = 2'd0;
        tick();
        total++;
        if (rd0 !== 32'd2 || rd0 !== m_rd[0]) begin
            bad++; $display("FAIL clear_data got %0h exp 2", rd0);
        end
    endtask

    task automatic test_fall_pulse();
        in_port = 3'b000;
        repeat (4) tick();
        bus_write(2'd3, 32'h7);
        in_port = 3'b010;
        repeat (3) tick();
        in_port = 3'b000;
        repeat (4) tick();
        addr = 2'd3;
        tick();
        total++;
        if (rd1 !== 32'd2) begin
            bad++; $display("FAIL fall_pulse got %0h exp 2", rd1);
        end
        total++;
        if (rd0 !== m_rd[0]) begin
            bad++; $display("FAIL fall_pulse_u0 got %0h exp %0h", rd0, m_rd[0]);
        end
    endtask

    task automatic test_mask_write();
        bus_write(2'd3, 32'h7);
        bus_write(2'd2, 32'h0);
        in_port = 3'b001;
        bus_write(2'd2, 32'hFFFF_FFFF);
        addr = 2'd2;
        tick();
        total++;
        if (rd0 !== (IRQ_EN ? 32'd7 : 32'd0)) begin
            bad++; $display("FAIL mask_read got %0h exp %0h", rd0, IRQ_EN ? 7 : 0);
        end
        repeat (3) tick();
        addr = 2'd3;
        tick();
        total++;
        if (rd0 !== 32'd1 || irq0 !== IRQ_EN) begin
            bad++; $display("FAIL mask_edge got %0h/%b exp 1/%b", rd0, irq0, IRQ_EN);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = 3'($urandom);
            addr = 2'($urandom);
            wd   = $urandom;
            cs   = ($urandom_range(0, 2) == 0);
            wn   = ($urandom_range(0, 1) == 0);
            tick();
            total++;
            if (rd0 !== m_rd[0] || rd1 !== m_rd[1]) begin
                bad++;
                $display("FAIL rand_rd c%0d got %0h/%0h exp %0h/%0h",
                         i, rd0, rd1, m_rd[0], m_rd[1]);
            end
            total++;
            if (irq0 !== m_irq[0] || irq1 !== m_irq[1]) begin
                bad++;
                $display("FAIL rand_irq c%0d got %b/%b exp %b/%b",
                         i, irq0, irq1, m_irq[0], m_irq[1]);
            end
        end
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic test_mid_reset();
        in_port = 3'b111;
        addr = 2'd0;
        bus_write(2'd2, 32'h7);
        repeat (3) tick();
        #3 reset_n = 1'b0;
        #1;
        total++;
        if (rd0 !== 32'd0 || irq0 !== 1'b0 || rd1 !== 32'd0) begin
            bad++; $display("FAIL async_reset got %0h/%b/%0h exp 0", rd0, irq0, rd1);
        end
        model_reset();
        tick();
        reset_n = 1'b1;
        addr = 2'd3;
        repeat (6) tick();
        total++;
        if (rd0 !== 32'd0 || rd1 !== 32'd0 || irq0 !== 1'b0) begin
            bad++; $display("FAIL rearm_edge got %0h/%0h/%b exp 0", rd0, rd1, irq0);
        end
        addr = 2'd0;
        tick();
        total++;
        if (rd0 !== 32'd7 || rd0 !== m_rd[0]) begin
            bad++; $display("FAIL rearm_data got %0h exp 7", rd0);
        end
    endtask

    initial begin
        test_reset();
        test_rise_irq();
        test_clear_collision();
        test_clear_all();
        test_fall_pulse();
        test_mask_write();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
